// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: word/half/byte loads with extension, sub-word stores via read-modify-write.
// Optional macro MISALIGN_EXC_EN: misaligned requests raise exc instead of accessing memory.
module mem_access_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_valid,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] st_data,
  input  logic [31:0]   pc_in,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] ld_data,
  output logic          exc,
  output logic          memw,
  output logic          memr,
  output logic [AW-1:0] add,
  output logic [DW-1:0] wdata,
  output logic [31:0]   PC,
  input  logic [DW-1:0] rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_MERGE = 1'b1} state_t;

  state_t        r_state;
  logic [31:0]   r_merge;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_st;
  logic [31:0]   r_pc;
  logic          r_is_byte;

  logic          w_is_load;
  logic          w_is_sw;
  logic          w_is_sub;
  logic          w_mis_block;
  logic [31:0]   w_merged;

  function automatic logic [31:0] f_load_ext(input logic [2:0] f_op, input logic [1:0] f_lane,
                                             input logic [31:0] f_word);
    logic [15:0] v_half;
    logic [7:0]  v_byte;
    v_half = f_lane[1] ? f_word[31:16] : f_word[15:0];
    case (f_lane)
      2'd0:    v_byte = f_word[7:0];
      2'd1:    v_byte = f_word[15:8];
      2'd2:    v_byte = f_word[23:16];
      2'd3:    v_byte = f_word[31:24];
      default: v_byte = f_word[7:0];
    endcase
    case (f_op)
      OP_LH:   return {{16{v_half[15]}}, v_half};
      OP_LHU:  return {16'h0000, v_half};
      OP_LB:   return {{24{v_byte[7]}}, v_byte};
      OP_LBU:  return {24'h000000, v_byte};
      default: return f_word;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic f_byte, input logic [1:0] f_lane,
                                          input logic [31:0] f_word, input logic [15:0] f_data);
    logic [31:0] v_word;
    v_word = f_word;
    if (f_byte) begin
      case (f_lane)
        2'd0:    v_word[7:0]   = f_data[7:0];
        2'd1:    v_word[15:8]  = f_data[7:0];
        2'd2:    v_word[23:16] = f_data[7:0];
        2'd3:    v_word[31:24] = f_data[7:0];
        default: v_word[7:0]   = f_data[7:0];
      endcase
    end else if (f_lane[1]) begin
      v_word[31:16] = f_data;
    end else begin
      v_word[15:0] = f_data;
    end
    return v_word;
  endfunction

  assign w_is_load = (op <= OP_LBU);
  assign w_is_sw   = (op == OP_SW);
  assign w_is_sub  = (op == OP_SH) || (op == OP_SB);
  assign w_merged  = f_merge(r_is_byte, r_addr[1:0], r_merge, r_st);

`ifdef MISALIGN_EXC_EN
  // Alignment check: words need addr[1:0]=0, halves need addr[0]=0
  always_comb begin
    w_mis_block = 1'b0;
    case (op)
      OP_LW, OP_SW:         w_mis_block = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_mis_block = addr[0];
      default:              w_mis_block = 1'b0;
    endcase
  end

  // Exception pulse, one cycle after a misaligned request
  always_ff @(posedge clk or posedge clr) begin
    if (clr) exc <= 1'b0;
    else     exc <= (r_state == S_IDLE) && req_valid && w_mis_block;
  end
`else
  assign w_mis_block = 1'b0;
  assign exc         = 1'b0;
`endif

  // Memory strobes and address/data muxing; clr kills strobes at once, including an in-flight merge write
  always_comb begin
    memr  = 1'b0;
    memw  = 1'b0;
    stall = 1'b0;
    add   = {addr[AW-1:2], 2'b00};
    wdata = st_data;
    PC    = pc_in;
    if (clr) begin
      memr  = 1'b0;
      memw  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && !w_mis_block) begin
            memr  = w_is_load || w_is_sub;
            memw  = w_is_sw;
            stall = w_is_sub;
          end else begin
            memr  = 1'b0;
            memw  = 1'b0;
          end
        end
        S_MERGE: begin
          memw  = 1'b1;
          stall = 1'b1;
          add   = {r_addr[AW-1:2], 2'b00};
          wdata = w_merged;
          PC    = r_pc;
        end
        default: begin
          memr  = 1'b0;
          memw  = 1'b0;
        end
      endcase
    end
  end

  // Access FSM, load result register and RMW capture registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      done      <= 1'b0;
      ld_data   <= '0;
      r_merge   <= 32'h0000_0000;
      r_addr    <= '0;
      r_st      <= 16'h0000;
      r_pc      <= 32'h0000_0000;
      r_is_byte <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_mis_block) begin
              done <= 1'b1;
            end else if (w_is_sub) begin
              r_merge   <= rdata;
              r_addr    <= addr;
              r_st      <= st_data[15:0];
              r_pc      <= pc_in;
              r_is_byte <= (op == OP_SB);
              r_state   <= S_MERGE;
            end else begin
              done <= 1'b1;
              if (w_is_load) ld_data <= f_load_ext(op, addr[1:0], rdata);
            end
          end
        end
        S_MERGE: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: word memory model, load scoreboard, per-scenario tasks.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] addr, st_data, pc_in, rdata;
  logic        stall, done, exc, memw, memr;
  logic [31:0] ld_data, add, wdata, PC;

  logic [31:0] mem [0:63];
  logic        tb_poke;
  logic [5:0]  tb_idx;
  logic [31:0] tb_val;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_access_ctrl dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .op(op), .addr(addr),
    .st_data(st_data), .pc_in(pc_in), .stall(stall), .done(done),
    .ld_data(ld_data), .exc(exc), .memw(memw), .memr(memr), .add(add),
    .wdata(wdata), .PC(PC), .rdata(rdata)
  );

  always #5 clk = ~clk;

  assign rdata = mem[add[7:2]];

  always @(posedge clk) begin
    if (tb_poke) mem[tb_idx] <= tb_val;
    else if (memw) mem[add[7:2]] <= wdata;
  end

  always @(negedge clk) begin
    if (!clr) begin
      n_checks++;
      if (memw && memr) begin
        n_fail++;
        $display("FAIL strobe_excl: memw=%0b memr=%0b, required not both 1", memw, memr);
      end
      n_checks++;
      if (add[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL add_aligned: add=%h, required low bits 00", add);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    tb_poke = 1'b1;
    tb_idx  = idx[5:0];
    tb_val  = val;
    tick();
    tb_poke = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; op = 3'b101; addr = 32'h30; st_data = 32'h5555AAAA; pc_in = 32'h100;
    tick(); tick();
    at_neg();
    n_checks++; if (memw !== 1'b0) begin n_fail++; $display("FAIL reset_memw: got %0b expected 0", memw); end
    n_checks++; if (memr !== 1'b0) begin n_fail++; $display("FAIL reset_memr: got %0b expected 0", memr); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (ld_data !== 32'h0) begin n_fail++; $display("FAIL reset_ld_data: got %h expected 00000000", ld_data); end
    tick();
    clr = 1'b0;
    at_neg();
    n_checks++; if (memw !== 1'b1) begin n_fail++; $display("FAIL rel_sw_memw: got %0b expected 1", memw); end
    n_checks++; if (add !== 32'h30) begin n_fail++; $display("FAIL rel_sw_add: got %h expected 00000030", add); end
    n_checks++; if (wdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL rel_sw_wdata: got %h expected 5555aaaa", wdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rel_sw_stall: got %0b expected 0", stall); end
    tick();
    req_valid = 1'b0;
    at_neg();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rel_sw_done: got %0b expected 1", done); end
    n_checks++; if (mem[12] !== 32'h5555AAAA) begin n_fail++; $display("FAIL rel_sw_mem: got %h expected 5555aaaa", mem[12]); end
  endtask

  task automatic test_idle();
    tick();
    at_neg();
    n_checks++; if ({memr, memw, stall, done} !== 4'b0000) begin
      n_fail++; $display("FAIL idle: memr/memw/stall/done got %b expected 0000", {memr, memw, stall, done});
    end
  endtask

  task automatic test_loads();
    logic [2:0]  t_op  [4] = '{3'b011, 3'b100, 3'b001, 3'b010};
    logic [31:0] t_addr[4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] t_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8081, 32'h0000F2F3};
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 1'b1; op = t_op[i]; addr = t_addr[i];
      exp_q.push_back(t_exp[i]);
      at_neg();
      n_checks++; if (memr !== 1'b1 || add !== 32'h10) begin
        n_fail++; $display("FAIL load%0d_req: memr=%0b add=%h expected 1 and 00000010", i, memr, add);
      end
      n_checks++; if (done !== 1'b0 || stall !== 1'b0) begin
        n_fail++; $display("FAIL load%0d_early: done=%0b stall=%0b expected 0 0", i, done, stall);
      end
      tick();
      req_valid = 1'b0;
      at_neg();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL load%0d_done: got %0b expected 1", i, done); end
      got = exp_q.pop_front();
      n_checks++; if (ld_data !== got) begin n_fail++; $display("FAIL load%0d_data: got %h expected %h", i, ld_data, got); end
    end
  endtask

  task automatic test_sb_rmw();
    tick();
    req_valid = 1'b1; op = 3'b111; addr = 32'h21; st_data = 32'h000000AB; pc_in = 32'h200;
    at_neg();
    n_checks++; if (memr !== 1'b1 || memw !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL sb_c0: memr=%0b memw=%0b stall=%0b expected 1 0 1", memr, memw, stall);
    end
    tick();
    pc_in = 32'h204;
    at_neg();
    n_checks++; if (memw !== 1'b1 || memr !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL sb_c1_strobes: memw=%0b memr=%0b stall=%0b expected 1 0 1", memw, memr, stall);
    end
    n_checks++; if (add !== 32'h20) begin n_fail++; $display("FAIL sb_c1_add: got %h expected 00000020", add); end
    n_checks++; if (wdata !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_c1_wdata: got %h expected 1122ab44", wdata); end
    n_checks++; if (PC !== 32'h200) begin n_fail++; $display("FAIL sb_c1_pc: got %h expected 00000200", PC); end
    tick();
    req_valid = 1'b0;
    at_neg();
    n_checks++; if (done !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL sb_c2: done=%0b stall=%0b expected 1 0", done, stall);
    end
    n_checks++; if (mem[8] !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_mem: got %h expected 1122ab44", mem[8]); end
  endtask

  task automatic test_back_to_back();
    tick();
    poke(8, 32'h11223344);
    req_valid = 1'b1; op = 3'b110; addr = 32'h22; st_data = 32'hDEADBEEF; pc_in = 32'h300;
    at_neg();
    n_checks++; if (memr !== 1'b1 || stall !== 1'b1) begin
      n_fail++; $display("FAIL sh_c0: memr=%0b stall=%0b expected 1 1", memr, stall);
    end
    tick();
    op = 3'b011; addr = 32'h3C; st_data = 32'h0;
    at_neg();
    n_checks++; if (memw !== 1'b1 || add !== 32'h20) begin
      n_fail++; $display("FAIL sh_c1: memw=%0b add=%h expected 1 00000020", memw, add);
    end
    n_checks++; if (wdata !== 32'hBEEF3344) begin n_fail++; $display("FAIL sh_c1_wdata: got %h expected beef3344", wdata); end
    tick();
    op = 3'b000; addr = 32'h20;
    exp_q.push_back(32'hBEEF3344);
    at_neg();
    n_checks++; if (done !== 1'b1 || memr !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: done=%0b memr=%0b stall=%0b expected 1 1 0", done, memr, stall);
    end
    tick();
    req_valid = 1'b0;
    at_neg();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_lw_done: got %0b expected 1", done); end
    got = exp_q.pop_front();
    n_checks++; if (ld_data !== got) begin n_fail++; $display("FAIL b2b_lw_data: got %h expected %h", ld_data, got); end
  endtask

  task automatic test_abort();
    tick();
    poke(8, 32'h11223344);
    req_valid = 1'b1; op = 3'b111; addr = 32'h20; st_data = 32'h00000077;
    at_neg();
    n_checks++; if (memr !== 1'b1) begin n_fail++; $display("FAIL abort_c0: memr got %0b expected 1", memr); end
    tick();
    clr = 1'b1;
    at_neg();
    n_checks++; if (memw !== 1'b0) begin n_fail++; $display("FAIL abort_memw: got %0b expected 0", memw); end
    tick();
    clr = 1'b0; req_valid = 1'b0;
    at_neg();
    n_checks++; if (done !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL abort_done: done=%0b stall=%0b expected 0 0", done, stall);
    end
    tick();
    req_valid = 1'b1; op = 3'b000; addr = 32'h20;
    exp_q.push_back(32'h11223344);
    tick();
    req_valid = 1'b0;
    at_neg();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_lw_done: got %0b expected 1", done); end
    got = exp_q.pop_front();
    n_checks++; if (ld_data !== got) begin n_fail++; $display("FAIL abort_lw_data: got %h expected %h", ld_data, got); end
  endtask

  task automatic test_misalign();
    tick();
    req_valid = 1'b1; op = 3'b000; addr = 32'h1A;
`ifdef MISALIGN_EXC_EN
    at_neg();
    n_checks++; if (memr !== 1'b0 || memw !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL mis_req: memr=%0b memw=%0b stall=%0b expected 0 0 0", memr, memw, stall);
    end
    tick();
    req_valid = 1'b0;
    at_neg();
    n_checks++; if (exc !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL mis_exc: exc=%0b done=%0b expected 1 1", exc, done);
    end
    n_checks++; if (ld_data !== 32'h11223344) begin n_fail++; $display("FAIL mis_ld_kept: got %h expected 11223344", ld_data); end
`else
    exp_q.push_back(32'hCAFE1234);
    at_neg();
    n_checks++; if (memr !== 1'b1 || add !== 32'h18) begin
      n_fail++; $display("FAIL mis_req: memr=%0b add=%h expected 1 00000018", memr, add);
    end
    tick();
    req_valid = 1'b0;
    at_neg();
    n_checks++; if (done !== 1'b1 || exc !== 1'b0) begin
      n_fail++; $display("FAIL mis_done: done=%0b exc=%0b expected 1 0", done, exc);
    end
    got = exp_q.pop_front();
    n_checks++; if (ld_data !== got) begin n_fail++; $display("FAIL mis_data: got %h expected %h", ld_data, got); end
`endif
  endtask

  initial begin
    clr = 1'b1; req_valid = 1'b0; op = 3'b000; addr = 32'h0; st_data = 32'h0; pc_in = 32'h0;
    tb_poke = 1'b0; tb_idx = 6'd0; tb_val = 32'h0;
    tick();
    poke(4, 32'h8081F2F3);
    poke(8, 32'h11223344);
    poke(6, 32'hCAFE1234);
    poke(12, 32'h0);
    test_reset();
    test_idle();
    test_loads();
    test_sb_rmw();
    test_back_to_back();
    test_abort();
    test_misalign();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
